// File: rtl/vga_scan_reader.sv
// Read-side scan controller: 640x480 VGA timing with 2x2 replication of a 320x240 buffer.
// Three-stage flow: counters -> registered buffer address/flags -> registered pins.
module vga_scan_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        Clock,
  input  logic        Resetn,
  output logic [7:0]  row_read,
  output logic [8:0]  col_read,
  input  logic [11:0] pixel_out,
  output logic [11:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  logic       h_act, v_act, hs_next, vs_next, sof_next;
  logic       act1_reg, hs1_reg, vs1_reg, sof1_reg;

  always_comb begin
    h_cnt_next = h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
    end
  end

  // Stage-1 decode of the current counter position.
  always_comb begin
    h_act    = (h_cnt_reg < H_VIS);
    v_act    = (v_cnt_reg < V_VIS);
    hs_next  = !((h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END));
    vs_next  = !((v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END));
    sof_next = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Dropping the counter LSBs repeats each stored pixel over 2 columns and 2 lines.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      row_read <= '0;
      col_read <= '0;
      act1_reg <= 1'b0;
      hs1_reg  <= 1'b1;
      vs1_reg  <= 1'b1;
      sof1_reg <= 1'b0;
    end else begin
      row_read <= v_act ? v_cnt_reg[8:1] : '0;
      col_read <= h_act ? h_cnt_reg[9:1] : '0;
      act1_reg <= h_act && v_act;
      hs1_reg  <= hs_next;
      vs1_reg  <= vs_next;
      sof1_reg <= sof_next;
    end
  end

  // pixel_out arrives combinationally for the stage-1 address, so it lines up with act1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vga_rgb     <= '0;
      video_on    <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_rgb     <= act1_reg ? pixel_out : 12'h000;
      video_on    <= act1_reg;
      vga_hsync   <= hs1_reg;
      vga_vsync   <= vs1_reg;
      frame_start <= sof1_reg;
    end
  end

endmodule

// File: tb/tb_vga_scan_reader.sv
// Bench for vga_scan_reader: per-cycle expected pins from a position-in-frame model,
// scoreboarded against the DUT on the falling edge, plus reset and frame-period checks.
module tb_vga_scan_reader;

  localparam int H_ACT = 640, H_FP = 16, H_SYN = 96, H_BP = 48;
  localparam int V_ACT = 12,  V_FP = 2,  V_SYN = 2,  V_BP = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        Clock;
  logic        Resetn;
  logic [7:0]  row_read;
  logic [8:0]  col_read;
  logic [11:0] pixel_out;
  logic [11:0] vga_rgb;
  logic        vga_hsync, vga_vsync, video_on, frame_start;

  logic [11:0] mem [240][320];
  logic        pix_fff;
  logic        pattern_mode;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        hs, vs, von, fs;
    logic [7:0]  row;
    logic [8:0]  col;
    logic        vis;
    int          x, y;
  } exp_t;

  exp_t exp_q[$];

  vga_scan_reader #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .row_read   (row_read),
    .col_read   (col_read),
    .pixel_out  (pixel_out),
    .vga_rgb    (vga_rgb),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .video_on   (video_on),
    .frame_start(frame_start)
  );

  // Combinational buffer model.
  assign pixel_out = pix_fff ? 12'hFFF : mem[row_read][col_read];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic exp_t idle_exp();
    exp_t e;
    e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.fs = 1'b0;
    e.row = '0; e.col = '0; e.vis = 1'b0; e.x = -1; e.y = -1;
    return e;
  endfunction

  // k = rising edges since reset release; pins show frame position k-2, address k-1.
  function automatic exp_t make_exp(int k);
    exp_t e;
    int pos, x, y;
    e = idle_exp();
    if (k - 1 >= 0) begin
      pos = (k - 1) % FRAME;
      x = pos % H_TOT;
      y = pos / H_TOT;
      e.col = (x < H_ACT) ? 9'(x / 2) : 9'd0;
      e.row = (y < V_ACT) ? 8'(y / 2) : 8'd0;
    end
    if (k - 2 >= 0) begin
      pos = (k - 2) % FRAME;
      x = pos % H_TOT;
      y = pos / H_TOT;
      e.x   = x;
      e.y   = y;
      e.vis = (x < H_ACT) && (y < V_ACT);
      e.von = e.vis;
      e.hs  = !((x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SYN));
      e.vs  = !((y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SYN));
      e.fs  = (pos == 0);
      e.rgb = e.vis ? mem[y / 2][x / 2] : 12'h000;
    end
    return e;
  endfunction

  // Model: one expectation per rising edge.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge Clock);
      if (!Resetn) k = 0;
      else k = k + 1;
      exp_q.push_back(make_exp(k));
    end
  end

  // Monitor: compares every cycle on the falling edge.
  initial begin
    exp_t e;
    int neg_idx, last_fs;
    neg_idx = 0;
    last_fs = -1;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!Resetn) begin
          e = idle_exp();
          neg_idx = 0;
          last_fs = -1;
        end else begin
          neg_idx = neg_idx + 1;
        end
        tests = tests + 1;
        if (vga_rgb !== e.rgb || vga_hsync !== e.hs || vga_vsync !== e.vs ||
            video_on !== e.von || frame_start !== e.fs ||
            row_read !== e.row || col_read !== e.col) begin
          fails = fails + 1;
          $display("FAIL cycle x=%0d y=%0d: got rgb=%h hs=%b vs=%b von=%b fs=%b row=%0d col=%0d, want rgb=%h hs=%b vs=%b von=%b fs=%b row=%0d col=%0d",
                   e.x, e.y, vga_rgb, vga_hsync, vga_vsync, video_on, frame_start, row_read, col_read,
                   e.rgb, e.hs, e.vs, e.von, e.fs, e.row, e.col);
        end
        if (pattern_mode && Resetn && e.vis && e.x == 10 && e.y == 6) begin
          tests = tests + 1;
          if (vga_rgb !== 12'h305) begin
            fails = fails + 1;
            $display("FAIL pixel_10_6: got %h want 305", vga_rgb);
          end
        end
        if (Resetn && frame_start === 1'b1) begin
          tests = tests + 1;
          if (last_fs < 0) begin
            if (neg_idx != 2) begin
              fails = fails + 1;
              $display("FAIL first_sof: got %0d clocks after release want 2", neg_idx);
            end
          end else if (neg_idx - last_fs != FRAME) begin
            fails = fails + 1;
            $display("FAIL sof_period: got %0d want %0d", neg_idx - last_fs, FRAME);
          end
          last_fs = neg_idx;
        end
      end
    end
  end

  task automatic check_reset(input string name);
    tests = tests + 1;
    if (vga_rgb !== 12'h000 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1 ||
        video_on !== 1'b0 || frame_start !== 1'b0 || row_read !== 8'd0 || col_read !== 9'd0) begin
      fails = fails + 1;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b von=%b fs=%b row=%0d col=%0d, want rgb=000 hs=1 vs=1 von=0 fs=0 row=0 col=0",
               name, vga_rgb, vga_hsync, vga_vsync, video_on, frame_start, row_read, col_read);
    end
  endtask

  initial begin
    Resetn = 1'b0;
    pix_fff = 1'b1;
    pattern_mode = 1'b1;
    for (int r = 0; r < 240; r++)
      for (int c = 0; c < 320; c++)
        mem[r][c] = {r[3:0], c[7:0]};

    repeat (4) @(posedge Clock);
    #2 check_reset("reset_hold");
    @(negedge Clock);
    #1 pix_fff = 1'b0;
    Resetn = 1'b1;

    // Asynchronous reset mid-line at h=300 of line 8.
    repeat (8 * H_TOT + 300) @(posedge Clock);
    #2 Resetn = 1'b0;
    #1 check_reset("async_h300");

    repeat (3) @(posedge Clock);
    pattern_mode = 1'b0;
    for (int r = 0; r < 240; r++)
      for (int c = 0; c < 320; c++)
        mem[r][c] = 12'($urandom);
    @(negedge Clock);
    #1 Resetn = 1'b1;

    // Two full frames, then reset mid-frame at line 10 with a random column.
    repeat (2 * FRAME + 10 * H_TOT + 37 + $urandom_range(0, 500)) @(posedge Clock);
    #2 Resetn = 1'b0;
    #1 check_reset("async_v10");

    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1 Resetn = 1'b1;
    repeat (FRAME + 100) @(posedge Clock);
    @(negedge Clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
